// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM/parity types and bit_index width for the UART transmitter
package uart_pkg;
  localparam int BIT_IDX_W = 4;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_mode_t;
endpackage

// File: rtl/uart_baud_div.sv
// uart_baud_div: bit-period counter, held at 0 by clr_i, pulses bit_end_o on the last cycle of a bit
module uart_baud_div #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q;
  assign bit_end_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1, wrapping at each bit boundary
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i || bit_end_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready word in, LSB-first UART frame out; parity built only with UART_TX_PARITY_EN
module uart_tx_serializer import uart_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
  output logic                 data_tx,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic [BIT_IDX_W-1:0] bit_index
);
  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic tx_q, tx_d, act_q, act_d, done_q, done_d;
  logic bit_end, last_data, last_stop;
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_q, par_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif
  assign tx_ready    = state_q == IDLE && !reset;
  assign data_tx     = tx_q;
  assign active_flag = act_q;
  assign done_flag   = done_q;
  assign bit_index   = idx_q;
  assign last_data   = cnt_q == 4'(DATA_BITS - 1);
  assign last_stop   = cnt_q == 4'(STOP_BITS - 1);
  uart_baud_div #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_div (
    .clk      (baud_clk),
    .rst      (reset),
    .clr_i    (state_q == IDLE),
    .bit_end_o(bit_end)
  );
  // next state and next registered outputs; the line value is computed one cycle ahead
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    act_d   = act_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = START;
        shreg_d = data_in;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b0;
        act_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_en_d = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        par_d    = parity_mode == PAR_ODD ? ~^data_in : ^data_in;
`endif
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + 1'b1;
      end
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + 1'b1;
        cnt_d   = last_data ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        state_d = last_data ? (par_en_q ? PARITY : STOP) : DATA;
        tx_d    = last_data ? (par_en_q ? par_q : 1'b1) : shreg_q[0];
`else
        state_d = last_data ? STOP : DATA;
        tx_d    = last_data ? 1'b1 : shreg_q[0];
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
        idx_d   = idx_q + 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        state_d = last_stop ? IDLE : STOP;
        act_d   = !last_stop;
        done_d  = last_stop;
        idx_d   = last_stop ? '0 : idx_q + 1'b1;
        cnt_d   = last_stop ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any frame and idles the line high
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end
endmodule
